// File: rtl/out_channel_reader_if.sv
// Bundles the expected-table load port, run control, out-channel handshake and result signals.
// CAPTURE_READBACK_EN adds the capture readback port (readAddr/readData).
interface out_channel_reader_if #(
  parameter int MemoryElementWidth = 12,
  parameter int CountWidth = 8
);
  logic                          expectWe;
  logic [CountWidth-1:0]         expectAddr;
  logic [MemoryElementWidth-1:0] expectData;
  logic [CountWidth-1:0]         expectCount;
  logic                          start;
  logic                          outValid;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outReady;
  logic                          finished;
  logic                          success;
  logic                          timedOut;
  logic [CountWidth-1:0]         received;
  logic [CountWidth-1:0]         mismatchIndex;
`ifdef CAPTURE_READBACK_EN
  logic [CountWidth-1:0]         readAddr;
  logic [MemoryElementWidth-1:0] readData;
`endif

  modport master (
    output expectWe, expectAddr, expectData, expectCount, start, outValid, outData,
`ifdef CAPTURE_READBACK_EN
    output readAddr,
    input  readData,
`endif
    input  outReady, finished, success, timedOut, received, mismatchIndex
  );

  modport slave (
    input  expectWe, expectAddr, expectData, expectCount, start, outValid, outData,
`ifdef CAPTURE_READBACK_EN
    input  readAddr,
    output readData,
`endif
    output outReady, finished, success, timedOut, received, mismatchIndex
  );
endinterface

// File: rtl/out_channel_reader.sv
// Receives the machine's out-channel words and compares them in order against a preloaded table.
// Optional feature macro CAPTURE_READBACK_EN: capture buffer of accepted words with registered readback.
module out_channel_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpect = 16,
  parameter int TimeoutCycles = 1000,
  parameter int CountWidth = 8
) (
  input logic                 clock,
  input logic                 reset,
  out_channel_reader_if.slave bus
);
  localparam int AddrWidth = (NExpect > 1) ? $clog2(NExpect) : 1;
  localparam int IdleWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CountWidth-1:0] DepthCount = CountWidth'(NExpect);
  localparam logic [CountWidth-1:0] NoMismatch = '1;
  localparam logic [IdleWidth-1:0]  IdleLast   = IdleWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state_reg;
  logic [MemoryElementWidth-1:0] expect_mem [NExpect];
  logic [CountWidth-1:0]         count_reg;
  logic [CountWidth-1:0]         received_reg;
  logic [CountWidth-1:0]         mismatch_reg;
  logic [CountWidth-1:0]         mismatch_next;
  logic [CountWidth-1:0]         received_inc;
  logic [CountWidth-1:0]         count_clamped;
  logic [IdleWidth-1:0]          idle_reg;
  logic                          finished_reg;
  logic                          success_reg;
  logic                          timed_out_reg;
  logic                          out_ready;
  logic                          transfer;
  logic [MemoryElementWidth-1:0] expected_word;

  assign received_inc  = received_reg + CountWidth'(1);
  assign count_clamped = (bus.expectCount > DepthCount) ? DepthCount : bus.expectCount;
  // Ready is masked once the count is met so a zero-length run never swallows a word.
  assign out_ready     = (state_reg == RUN) && (received_reg != count_reg);
  assign transfer      = out_ready && bus.outValid;
  assign expected_word = expect_mem[received_reg[AddrWidth-1:0]];

  always_comb begin
    mismatch_next = mismatch_reg;
    if (mismatch_reg == NoMismatch && bus.outData != expected_word) begin
      mismatch_next = received_reg;
    end
  end

  // Table contents survive reset; loading is only possible while idle.
  always_ff @(posedge clock) begin
    if (state_reg == IDLE && bus.expectWe && bus.expectAddr < DepthCount) begin
      expect_mem[bus.expectAddr[AddrWidth-1:0]] <= bus.expectData;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      received_reg  <= '0;
      mismatch_reg  <= NoMismatch;
      idle_reg      <= '0;
      finished_reg  <= 1'b0;
      success_reg   <= 1'b0;
      timed_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg     <= RUN;
            count_reg     <= count_clamped;
            received_reg  <= '0;
            mismatch_reg  <= NoMismatch;
            idle_reg      <= '0;
            finished_reg  <= 1'b0;
            success_reg   <= 1'b0;
            timed_out_reg <= 1'b0;
          end
        end
        RUN: begin
          if (transfer) begin
            received_reg <= received_inc;
            mismatch_reg <= mismatch_next;
            idle_reg     <= '0;
            if (received_inc == count_reg) begin
              state_reg    <= DONE;
              finished_reg <= 1'b1;
              success_reg  <= (mismatch_next == NoMismatch);
            end
          end else if (received_reg == count_reg) begin
            state_reg    <= DONE;
            finished_reg <= 1'b1;
            success_reg  <= (mismatch_reg == NoMismatch);
          end else if (idle_reg == IdleLast) begin
            idle_reg      <= idle_reg + IdleWidth'(1);
            state_reg     <= DONE;
            finished_reg  <= 1'b1;
            success_reg   <= 1'b0;
            timed_out_reg <= 1'b1;
          end else begin
            idle_reg <= idle_reg + IdleWidth'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.outReady      = out_ready;
  assign bus.finished      = finished_reg;
  assign bus.success       = success_reg;
  assign bus.timedOut      = timed_out_reg;
  assign bus.received      = received_reg;
  assign bus.mismatchIndex = mismatch_reg;

`ifdef CAPTURE_READBACK_EN
  logic [MemoryElementWidth-1:0] capture_mem [NExpect];
  logic [MemoryElementWidth-1:0] capture_q_reg;
  logic                          read_hit_reg;

  always_ff @(posedge clock) begin
    if (transfer) begin
      capture_mem[received_reg[AddrWidth-1:0]] <= bus.outData;
    end
    capture_q_reg <= capture_mem[bus.readAddr[AddrWidth-1:0]];
  end

  // Out-of-range reads are masked after the RAM register so the array still maps to block RAM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_hit_reg <= 1'b0;
    end else begin
      read_hit_reg <= (bus.readAddr < count_reg);
    end
  end

  assign bus.readData = read_hit_reg ? capture_q_reg : '0;
`endif
endmodule

// File: tb/tb_out_channel_reader.sv
// Self-checking bench for out_channel_reader: directed vector table, hand sequences, random runs vs a per-run model.
// Readback checks are included when CAPTURE_READBACK_EN is defined.
module tb_out_channel_reader;
  localparam int W  = 12;
  localparam int N  = 16;
  localparam int T  = 1000;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  out_channel_reader_if #(.MemoryElementWidth(W), .CountWidth(CW)) bus ();

  out_channel_reader #(
    .MemoryElementWidth(W), .NExpect(N), .TimeoutCycles(T), .CountWidth(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] tbl [N];
  logic [W-1:0] drv_words [N+1];
  int           drv_gaps  [N+1];

  typedef struct {
    int cnt;
    int t [4];
    int w [4];
    int g [4];
    int e_edges;
    int e_succ;
    int e_to;
    int e_recv;
    int e_mm;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic load(input int addr, input logic [W-1:0] d);
    bus.expectWe   = 1'b1;
    bus.expectAddr = CW'(addr);
    bus.expectData = d;
    @(posedge clock); #1;
    bus.expectWe = 1'b0;
    if (addr < N) tbl[addr] = d;
  endtask

  task automatic start_run(input int cnt);
    bus.expectCount = CW'(cnt);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Per-run outcome from the word/gap schedule: edges after the start edge until finished.
  task automatic model(input int cnt, output int e_edges, output int e_succ,
                       output int e_to, output int e_recv, output int e_mm);
    int c;
    c = (cnt > N) ? N : cnt;
    e_edges = 0; e_to = 0; e_recv = 0; e_mm = 255;
    for (int k = 0; k < c; k++) begin
      if (drv_gaps[k] >= T) begin
        e_to = 1;
        e_edges += T;
        break;
      end
      e_edges += drv_gaps[k] + 1;
      if (drv_words[k] != tbl[k] && e_mm == 255) e_mm = k;
      e_recv++;
    end
    if (c == 0) e_edges = 1;
    e_succ = (!e_to && e_mm == 255) ? 1 : 0;
  endtask

  task automatic drive_and_check(input string tag, input int e_edges, input int e_succ,
                                 input int e_to, input int e_recv, input int e_mm);
    int  i;
    int  gap;
    int  edges;
    bit  done;
    bit  xfer;
    i = 0; gap = drv_gaps[0]; edges = 0; done = 1'b0;
    while (!done && edges < 3000) begin
      if (gap > 0) begin
        bus.outValid = 1'b0;
      end else begin
        bus.outValid = 1'b1;
        bus.outData  = drv_words[i];
      end
      xfer = bus.outValid && bus.outReady;
      @(posedge clock); #1;
      edges++;
      if (xfer) begin
        if (i < N) i++;
        gap = drv_gaps[i];
      end else if (gap > 0) begin
        gap--;
      end
      done = bus.finished;
    end
    check({tag, "_finished"}, int'(bus.finished), 1);
    check({tag, "_edges"}, edges, e_edges);
    check({tag, "_success"}, int'(bus.success), e_succ);
    check({tag, "_timedout"}, int'(bus.timedOut), e_to);
    check({tag, "_received"}, int'(bus.received), e_recv);
    check({tag, "_mismatch"}, int'(bus.mismatchIndex), e_mm);
    // A further word must be back-pressured while the results hold.
    bus.outValid = 1'b1;
    bus.outData  = drv_words[i];
    repeat (3) begin
      @(posedge clock); #1;
    end
    check({tag, "_hold_ready"}, int'(bus.outReady), 0);
    check({tag, "_hold_received"}, int'(bus.received), e_recv);
    check({tag, "_hold_finished"}, int'(bus.finished), 1);
    bus.outValid = 1'b0;
  endtask

  task automatic clear_drv();
    for (int k = 0; k <= N; k++) begin
      drv_words[k] = '0;
      drv_gaps[k]  = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_edges, e_succ, e_to, e_recv, e_mm;
    int cnt;
    bit all_match;

    bus.expectWe = 1'b0; bus.expectAddr = '0; bus.expectData = '0;
    bus.expectCount = '0; bus.start = 1'b0; bus.outValid = 1'b0; bus.outData = '0;
`ifdef CAPTURE_READBACK_EN
    bus.readAddr = '0;
`endif
    for (int k = 0; k < N; k++) tbl[k] = '0;

    vecs[0] = '{1, '{2, 0, 0, 0},   '{2, 0, 0, 0},    '{0, 0, 0, 0},     1,     1, 0, 1, 255};
    vecs[1] = '{3, '{5, 7, 9, 0},   '{5, 8, 9, 0},    '{0, 2, 3, 0},     8,     0, 0, 3, 1};
    vecs[2] = '{2, '{11, 22, 0, 0}, '{11, 22, 0, 0},  '{1, T, 0, 0},     2 + T, 0, 1, 1, 255};
    vecs[3] = '{2, '{11, 22, 0, 0}, '{11, 22, 0, 0},  '{1, T - 1, 0, 0}, 2 + T, 1, 0, 2, 255};
    vecs[4] = '{2, '{11, 22, 0, 0}, '{11, 22, 33, 0}, '{0, 0, 0, 0},     2,     1, 0, 2, 255};
    vecs[5] = '{0, '{4, 0, 0, 0},   '{4, 0, 0, 0},    '{0, 0, 0, 0},     1,     1, 0, 0, 255};
    vecs[6] = '{3, '{1, 2, 3, 0},   '{9, 2, 8, 0},    '{0, 0, 0, 0},     3,     0, 0, 3, 0};
    vecs[7] = '{1, '{3, 0, 0, 0},   '{3, 0, 0, 0},    '{T, 0, 0, 0},     T,     0, 1, 0, 255};

    do_reset();
    check("reset_ready", int'(bus.outReady), 0);
    check("reset_finished", int'(bus.finished), 0);
    check("reset_success", int'(bus.success), 0);
    check("reset_timedout", int'(bus.timedOut), 0);
    check("reset_received", int'(bus.received), 0);
    check("reset_mismatch", int'(bus.mismatchIndex), 255);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int k = 0; k < 4; k++) load(k, W'(vecs[v].t[k]));
      clear_drv();
      for (int k = 0; k < 4; k++) begin
        drv_words[k] = W'(vecs[v].w[k]);
        drv_gaps[k]  = vecs[v].g[k];
      end
      start_run(vecs[v].cnt);
      drive_and_check($sformatf("vec%0d", v), vecs[v].e_edges, vecs[v].e_succ,
                      vecs[v].e_to, vecs[v].e_recv, vecs[v].e_mm);
`ifdef CAPTURE_READBACK_EN
      if (v == 1) begin
        bus.readAddr = CW'(1);
        @(posedge clock); #1;
        check("readback_addr1", int'(bus.readData), 8);
        bus.readAddr = CW'(3);
        @(posedge clock); #1;
        check("readback_addr3", int'(bus.readData), 0);
        bus.readAddr = '0;
      end
`endif
    end

    // Reset in the middle of a run abandons it; the table survives.
    do_reset();
    load(0, W'(5)); load(1, W'(7)); load(2, W'(9));
    start_run(3);
    bus.outValid = 1'b1; bus.outData = W'(5);
    @(posedge clock); #1;
    bus.outValid = 1'b0;
    check("midreset_pre_received", int'(bus.received), 1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("midreset_finished", int'(bus.finished), 0);
    check("midreset_received", int'(bus.received), 0);
    check("midreset_ready", int'(bus.outReady), 0);
    check("midreset_mismatch", int'(bus.mismatchIndex), 255);
    clear_drv();
    drv_words[0] = W'(5); drv_words[1] = W'(7); drv_words[2] = W'(9);
    model(3, e_edges, e_succ, e_to, e_recv, e_mm);
    start_run(3);
    drive_and_check("midreset_rerun", e_edges, e_succ, e_to, e_recv, e_mm);

    // Table write while DONE is dropped; start from DONE re-runs against the old table.
    bus.expectWe = 1'b1; bus.expectAddr = '0; bus.expectData = W'(12'h123);
    @(posedge clock); #1;
    bus.expectWe = 1'b0;
    start_run(3);
    drive_and_check("done_write", e_edges, e_succ, e_to, e_recv, e_mm);

    // A second start pulse during RUN must not relatch the count.
    drv_gaps[0] = 1;
    model(3, e_edges, e_succ, e_to, e_recv, e_mm);
    start_run(3);
    start_run(1);
    drv_gaps[0] = 0;
    drive_and_check("start_in_run", e_edges - 1, e_succ, e_to, e_recv, e_mm);

    // Write and start in the same IDLE cycle: the run sees the new word.
    do_reset();
    load(0, W'(100));
    bus.expectWe = 1'b1; bus.expectAddr = '0; bus.expectData = W'(42);
    bus.expectCount = CW'(1); bus.start = 1'b1;
    @(posedge clock); #1;
    bus.expectWe = 1'b0; bus.start = 1'b0;
    tbl[0] = W'(42);
    clear_drv();
    drv_words[0] = W'(42);
    model(1, e_edges, e_succ, e_to, e_recv, e_mm);
    drive_and_check("write_and_start", e_edges, e_succ, e_to, e_recv, e_mm);

    // Out-of-range table address is ignored.
    do_reset();
    load(0, W'(77));
    load(N, W'(200));
    clear_drv();
    drv_words[0] = W'(77);
    model(1, e_edges, e_succ, e_to, e_recv, e_mm);
    start_run(1);
    drive_and_check("addr_range", e_edges, e_succ, e_to, e_recv, e_mm);

    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int k = 0; k < N; k++) load(k, W'($urandom));
      cnt = $urandom_range(0, 20);
      all_match = ($urandom_range(0, 1) == 1);
      for (int k = 0; k <= N; k++) begin
        if (k < N && (all_match || $urandom_range(0, 99) < 85)) drv_words[k] = tbl[k];
        else drv_words[k] = W'($urandom);
        drv_gaps[k] = $urandom_range(0, 3);
      end
      if (r % 5 == 4) begin
        drv_gaps[$urandom_range(0, N - 1)] = ($urandom_range(0, 1) == 1) ? T + 2 : T - 1;
      end
      model(cnt, e_edges, e_succ, e_to, e_recv, e_mm);
      start_run(cnt);
      drive_and_check($sformatf("rand%0d", r), e_edges, e_succ, e_to, e_recv, e_mm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
